exec_sequencer: RTL and testbench

//  Multi-cycle RV32I execute-stage controller wrapped around the shared ALU.

---
 rtl/exec_sequencer_pkg.sv | 81 ++++++++
 rtl/exec_sequencer_alu.sv | 45 ++++
 rtl/exec_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_exec_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the RV32I execute sequencer and its ALU:
// opcode classes, funct3 codes, FSM state encoding and decode helpers.
package exec_sequencer_pkg;

    localparam int XLEN = 32;

    // instr[6:2] opcode classes
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    // ALU funct3 codes
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // branch funct3 codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CMP,
        ST_TGT,
        ST_DONE
    } state_t;

    function automatic logic opc_known(input logic [4:0] opc);
        return (opc == OPC_LOAD)   || (opc == OPC_STORE)
            || (opc == OPC_OP_IMM) || (opc == OPC_OP)
            || (opc == OPC_LUI)    || (opc == OPC_AUIPC)
            || (opc == OPC_JAL)    || (opc == OPC_JALR)
            || (opc == OPC_BRANCH);
    endfunction

    // Branches with funct3 010/011 have no defined comparison.
    function automatic logic instr_legal(
        input logic [4:0] opc,
        input logic [2:0] f3
    );
        if (!opc_known(opc))
            return 1'b0;
        if (opc == OPC_BRANCH && f3[2:1] == 2'b01)
            return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic opc_writes_rd(input logic [4:0] opc);
        return (opc == OPC_LUI)  || (opc == OPC_AUIPC)
            || (opc == OPC_JAL)  || (opc == OPC_JALR)
            || (opc == OPC_OP)   || (opc == OPC_OP_IMM)
            || (opc == OPC_LOAD);
    endfunction

    // ALU operation used by the compare pass of a branch.
    function automatic logic [2:0] cmp_f3(input logic [2:0] f3);
        unique case (f3[2:1])
            2'b00:   return F3_XOR;
            2'b10:   return F3_SLT;
            2'b11:   return F3_SLTU;
            default: return F3_XOR;
        endcase
    endfunction

endpackage

// File: rtl/exec_sequencer_alu.sv
// Shared RV32I ALU: arithmetic/logic for OP and OP-IMM, pass-through for
// LUI, and plain addition for every other opcode class.
// Ports: opcode1/2/3 select the operation, op1/op2 operands, result out.
// Shifts use the full op2 value; callers narrow the shift amount.
module exec_sequencer_alu
    import exec_sequencer_pkg::*;
(
    input  logic [4:0]  opcode1,
    input  logic [2:0]  opcode2,
    input  logic        opcode3,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] result
);

    logic is_arith;
    logic do_sub;

    assign is_arith = (opcode1 == OPC_OP) || (opcode1 == OPC_OP_IMM);
    // instr[30] in the immediate form is an immediate bit, not SUB
    assign do_sub   = (opcode1 == OPC_OP) && opcode3;

    always_comb begin
        result = '0;
        if (opcode1 == OPC_LUI) begin
            result = op1;
        end else if (is_arith) begin
            case (opcode2)
                F3_ADD:  result = do_sub ? op1 - op2 : op1 + op2;
                F3_SLL:  result = op1 << op2;
                F3_SLT:  result = {31'd0, $signed(op1) < $signed(op2)};
                F3_SLTU: result = {31'd0, op1 < op2};
                F3_XOR:  result = op1 ^ op2;
                F3_SR:   result = opcode3 ? 32'($signed(op1) >>> op2)
                                          : op1 >> op2;
                F3_OR:   result = op1 | op2;
                F3_AND:  result = op1 & op2;
                default: result = '0;
            endcase
        end else begin
            result = op1 + op2;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle RV32I execute-stage sequencer around the shared ALU.
// Ports: in_valid/in_ready take instr, pc, rs1_val, rs2_val, imm;
// out_valid/out_ready return rd_we, rd_addr, rd_value, mem_addr, is_load,
// is_store, next_pc, branch_taken and illegal.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_value,
    output logic [XLEN-1:0] mem_addr,
    output logic            is_load,
    output logic            is_store,
    output logic [XLEN-1:0] next_pc,
    output logic            branch_taken,
    output logic            illegal
);

    state_t state;
    state_t state_nxt;

    // in_ready stays low until the first clock after reset release
    logic started;

    logic [4:0]  opc_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic        b30_q;
    logic [31:0] pc_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] imm_q;
    logic        taken_q;

    logic [4:0]  opc_in;
    logic [2:0]  f3_in;
    logic        legal_in;
    logic        accept;

    logic [4:0]  alu_opc1;
    logic [2:0]  alu_opc2;
    logic        alu_opc3;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_res;

    logic [31:0] inc_base;
    logic [31:0] pc_plus4;
    logic        taken_c;
    logic        is_shift;
    logic        unused_bits;

    assign opc_in   = instr[6:2];
    assign f3_in    = instr[14:12];
    assign legal_in = instr_legal(opc_in, f3_in);
    assign unused_bits = ^{instr[31], instr[29:15], instr[1:0]};

    assign in_ready  = (state == ST_IDLE) && started;
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;

    // One incrementer: the incoming pc feeds it only for an illegal
    // op, which is resolved on the handshake cycle itself.
    assign inc_base = (state == ST_IDLE) ? pc : pc_q;
    assign pc_plus4 = inc_base + 32'd4;

    assign is_shift = ((opc_q == OPC_OP) || (opc_q == OPC_OP_IMM))
                   && ((f3_q == F3_SLL) || (f3_q == F3_SR));

    always_comb begin
        taken_c = 1'b0;
        unique case (f3_q)
            F3_BEQ:  taken_c = (alu_res == 32'd0);
            F3_BNE:  taken_c = (alu_res != 32'd0);
            F3_BLT,
            F3_BLTU: taken_c = alu_res[0];
            F3_BGE,
            F3_BGEU: taken_c = !alu_res[0];
            default: taken_c = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        alu_opc1  = '0;
        alu_opc2  = '0;
        alu_opc3  = 1'b0;
        alu_op1   = '0;
        alu_op2   = '0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!legal_in)
                        state_nxt = ST_DONE;
                    else if (opc_in == OPC_BRANCH)
                        state_nxt = ST_CMP;
                    else
                        state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_opc1 = opc_q;
                alu_opc2 = f3_q;
                alu_opc3 = b30_q;
                alu_op1  = rs1_q;
                alu_op2  = imm_q;
                unique case (opc_q)
                    OPC_LUI: begin
                        alu_op1 = imm_q;
                        alu_op2 = '0;
                    end
                    OPC_AUIPC,
                    OPC_JAL: alu_op1 = pc_q;
                    OPC_OP:  alu_op2 = rs2_q;
                    default: ;
                endcase
                if (is_shift)
                    alu_op2 = {27'd0, alu_op2[4:0]};
                state_nxt = ST_DONE;
            end
            ST_CMP: begin
                alu_opc1  = OPC_OP;
                alu_opc2  = cmp_f3(f3_q);
                alu_op1   = rs1_q;
                alu_op2   = rs2_q;
                state_nxt = ST_TGT;
            end
            ST_TGT: begin
                alu_opc1  = OPC_BRANCH;
                alu_opc2  = f3_q;
                alu_op1   = pc_q;
                alu_op2   = imm_q;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    exec_sequencer_alu u_alu (
        .opcode1 (alu_opc1),
        .opcode2 (alu_opc2),
        .opcode3 (alu_opc3),
        .op1     (alu_op1),
        .op2     (alu_op2),
        .result  (alu_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            started      <= 1'b0;
            opc_q        <= '0;
            f3_q         <= '0;
            rd_q         <= '0;
            b30_q        <= 1'b0;
            pc_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            taken_q      <= 1'b0;
            rd_we        <= 1'b0;
            rd_addr      <= '0;
            rd_value     <= '0;
            mem_addr     <= '0;
            is_load      <= 1'b0;
            is_store     <= 1'b0;
            next_pc      <= RESET_PC;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
            if (accept) begin
                opc_q <= opc_in;
                f3_q  <= f3_in;
                rd_q  <= instr[11:7];
                b30_q <= instr[30];
                pc_q  <= pc;
                rs1_q <= rs1_val;
                rs2_q <= rs2_val;
                imm_q <= imm;
                if (!legal_in) begin
                    rd_we        <= 1'b0;
                    rd_addr      <= instr[11:7];
                    rd_value     <= '0;
                    mem_addr     <= '0;
                    is_load      <= 1'b0;
                    is_store     <= 1'b0;
                    next_pc      <= pc_plus4;
                    branch_taken <= 1'b0;
                    illegal      <= 1'b1;
                end
            end
            if (state == ST_EXEC) begin
                rd_we        <= opc_writes_rd(opc_q) && (rd_q != 5'd0);
                rd_addr      <= rd_q;
                is_load      <= (opc_q == OPC_LOAD);
                is_store     <= (opc_q == OPC_STORE);
                branch_taken <= 1'b0;
                illegal      <= 1'b0;
                if (opc_q == OPC_JAL || opc_q == OPC_JALR)
                    rd_value <= pc_plus4;
                else
                    rd_value <= alu_res;
                if (opc_q == OPC_LOAD || opc_q == OPC_STORE)
                    mem_addr <= alu_res;
                else
                    mem_addr <= '0;
                if (opc_q == OPC_JAL)
                    next_pc <= alu_res;
                else if (opc_q == OPC_JALR)
                    next_pc <= {alu_res[31:1], 1'b0};
                else
                    next_pc <= pc_plus4;
            end
            if (state == ST_CMP)
                taken_q <= taken_c;
            if (state == ST_TGT) begin
                rd_we        <= 1'b0;
                rd_addr      <= rd_q;
                rd_value     <= '0;
                mem_addr     <= '0;
                is_load      <= 1'b0;
                is_store     <= 1'b0;
                branch_taken <= taken_q;
                illegal      <= 1'b0;
                next_pc      <= taken_q ? alu_res : pc_plus4;
            end
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer.
// Each task drives one scenario and checks results against constants.
module tb_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_value;
    logic [31:0] mem_addr;
    logic        is_load;
    logic        is_store;
    logic [31:0] next_pc;
    logic        branch_taken;
    logic        illegal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exec_sequencer #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .pc           (pc),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .imm          (imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .rd_we        (rd_we),
        .rd_addr      (rd_addr),
        .rd_value     (rd_value),
        .mem_addr     (mem_addr),
        .is_load      (is_load),
        .is_store     (is_store),
        .next_pc      (next_pc),
        .branch_taken (branch_taken),
        .illegal      (illegal)
    );

    task automatic issue(input logic [31:0] i_instr, input logic [31:0] i_pc,
                         input logic [31:0] i_rs1, input logic [31:0] i_rs2,
                         input logic [31:0] i_imm);
        @(negedge clk);
        in_valid = 1'b1;
        instr = i_instr;
        pc = i_pc;
        rs1_val = i_rs1;
        rs2_val = i_rs2;
        imm = i_imm;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Returns the cycle (handshake = cycle 0) in which out_valid rose, or -1.
    task automatic wait_done(output int lat);
        lat = -1;
        if (out_valid) begin
            lat = 1;
        end else begin
            for (int k = 2; k <= 12; k++) begin
                @(posedge clk);
                #1;
                if (out_valid) begin
                    lat = k;
                    break;
                end
            end
        end
    endtask

    task automatic accept();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({out_valid, rd_we, is_load, is_store, branch_taken, illegal} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                {out_valid, rd_we, is_load, is_store, branch_taken, illegal});
        end
        checks++;
        if ({rd_addr, rd_value, mem_addr, next_pc} !== '0) begin
            failures++;
            $display("FAIL reset_data rd_addr=%h rd_value=%h mem_addr=%h next_pc=%h exp=0",
                rd_addr, rd_value, mem_addr, next_pc);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_arith();
        int lat;
        logic [31:0] ins;
        ins = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
        issue(ins, 32'h200, 32'd5, 32'd7, 32'h0);
        wait_done(lat);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL add_latency got=%0d exp=2", lat);
        end
        checks++;
        if (rd_value !== 32'd12 || rd_we !== 1'b1 || rd_addr !== 5'd3) begin
            failures++;
            $display("FAIL add_result rd_value=%h rd_we=%b rd_addr=%0d exp=0000000c/1/3",
                rd_value, rd_we, rd_addr);
        end
        checks++;
        if (next_pc !== 32'h204 || mem_addr !== 32'h0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL add_misc next_pc=%h mem_addr=%h illegal=%b exp=204/0/0",
                next_pc, mem_addr, illegal);
        end
        accept();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL add_accept out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
        end
        ins = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4, 7'b0110011};
        issue(ins, 32'h204, 32'd5, 32'd7, 32'h0);
        wait_done(lat);
        checks++;
        if (rd_value !== 32'hFFFFFFFE || lat !== 2) begin
            failures++;
            $display("FAIL sub_result got=%h lat=%0d exp=fffffffe lat=2", rd_value, lat);
        end
        accept();
        ins = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0, 7'b0110011};
        issue(ins, 32'h208, 32'd1, 32'd1, 32'h0);
        wait_done(lat);
        checks++;
        if (rd_we !== 1'b0 || rd_value !== 32'd2) begin
            failures++;
            $display("FAIL add_x0 rd_we=%b rd_value=%h exp=0/2", rd_we, rd_value);
        end
        accept();
    endtask

    task automatic test_shift();
        int lat;
        logic [31:0] ins;
        ins = {7'b0100000, 5'd4, 5'd1, 3'b101, 5'd5, 7'b0010011};
        issue(ins, 32'h300, 32'h80000000, 32'h0, 32'h00000404);
        wait_done(lat);
        checks++;
        if (rd_value !== 32'hF8000000 || rd_we !== 1'b1) begin
            failures++;
            $display("FAIL srai rd_value=%h rd_we=%b exp=f8000000/1", rd_value, rd_we);
        end
        accept();
        ins = {7'b0000000, 5'd2, 5'd1, 3'b001, 5'd6, 7'b0110011};
        issue(ins, 32'h304, 32'h00000003, 32'h00000024, 32'h0);
        wait_done(lat);
        checks++;
        if (rd_value !== 32'h00000030) begin
            failures++;
            $display("FAIL sll_mask got=%h exp=00000030", rd_value);
        end
        accept();
    endtask

    task automatic test_branch();
        int lat;
        logic [31:0] ins;
        ins = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
        issue(ins, 32'h100, 32'd3, 32'd3, 32'h20);
        wait_done(lat);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL beq_latency got=%0d exp=3", lat);
        end
        checks++;
        if (branch_taken !== 1'b1 || next_pc !== 32'h120 || rd_we !== 1'b0) begin
            failures++;
            $display("FAIL beq taken=%b next_pc=%h rd_we=%b exp=1/120/0",
                branch_taken, next_pc, rd_we);
        end
        accept();
        ins = {7'b0000001, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011};
        issue(ins, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20);
        wait_done(lat);
        checks++;
        if (branch_taken !== 1'b0 || next_pc !== 32'h104 || rd_we !== 1'b0) begin
            failures++;
            $display("FAIL bltu taken=%b next_pc=%h rd_we=%b exp=0/104/0",
                branch_taken, next_pc, rd_we);
        end
        accept();
        ins = {7'b0000001, 5'd2, 5'd1, 3'b100, 5'd0, 7'b1100011};
        issue(ins, 32'h500, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0);
        wait_done(lat);
        checks++;
        if (branch_taken !== 1'b1 || next_pc !== 32'h4F0) begin
            failures++;
            $display("FAIL blt taken=%b next_pc=%h exp=1/4f0", branch_taken, next_pc);
        end
        accept();
    endtask

    task automatic test_jump_mem();
        int lat;
        logic [31:0] ins;
        ins = {12'h002, 5'd1, 3'b000, 5'd1, 7'b1100111};
        issue(ins, 32'h40, 32'h1001, 32'h0, 32'h2);
        wait_done(lat);
        checks++;
        if (next_pc !== 32'h1002 || rd_value !== 32'h44 || rd_we !== 1'b1) begin
            failures++;
            $display("FAIL jalr next_pc=%h rd_value=%h rd_we=%b exp=1002/44/1",
                next_pc, rd_value, rd_we);
        end
        accept();
        ins = {12'hFFC, 5'd1, 3'b010, 5'd6, 7'b0000011};
        issue(ins, 32'h60, 32'h1000, 32'h0, 32'hFFFFFFFC);
        wait_done(lat);
        checks++;
        if (mem_addr !== 32'hFFC || is_load !== 1'b1 || is_store !== 1'b0
            || rd_we !== 1'b1 || next_pc !== 32'h64) begin
            failures++;
            $display("FAIL lw mem_addr=%h ld=%b st=%b rd_we=%b next_pc=%h exp=ffc/1/0/1/64",
                mem_addr, is_load, is_store, rd_we, next_pc);
        end
        accept();
        ins = {7'b1111111, 5'd2, 5'd1, 3'b010, 5'b11100, 7'b0100011};
        issue(ins, 32'h64, 32'h2000, 32'h0, 32'hFFFFFFFC);
        wait_done(lat);
        checks++;
        if (mem_addr !== 32'h1FFC || is_store !== 1'b1 || is_load !== 1'b0
            || rd_we !== 1'b0) begin
            failures++;
            $display("FAIL sw mem_addr=%h st=%b ld=%b rd_we=%b exp=1ffc/1/0/0",
                mem_addr, is_store, is_load, rd_we);
        end
        accept();
    endtask

    task automatic test_illegal();
        int lat;
        logic [31:0] ins;
        ins = {20'h00000, 5'd7, 7'b1010111};
        issue(ins, 32'h80, 32'h1, 32'h2, 32'h3);
        wait_done(lat);
        checks++;
        if (illegal !== 1'b1 || rd_we !== 1'b0 || next_pc !== 32'h84 || lat < 1) begin
            failures++;
            $display("FAIL illegal_opc illegal=%b rd_we=%b next_pc=%h lat=%0d exp=1/0/84",
                illegal, rd_we, next_pc, lat);
        end
        accept();
        ins = {7'b0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b1100011};
        issue(ins, 32'h90, 32'h1, 32'h2, 32'h10);
        wait_done(lat);
        checks++;
        if (illegal !== 1'b1 || branch_taken !== 1'b0 || next_pc !== 32'h94) begin
            failures++;
            $display("FAIL illegal_branch illegal=%b taken=%b next_pc=%h exp=1/0/94",
                illegal, branch_taken, next_pc);
        end
        accept();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] ins;
        ins = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd9, 7'b0110011};
        issue(ins, 32'h30, 32'h10, 32'h20, 32'h0);
        wait_done(lat);
        ins = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd8, 7'b0110011};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            instr = ins;
            rs1_val = 32'h99;
            rs2_val = 32'h1;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || rd_value !== 32'h30
                || rd_addr !== 5'd9 || next_pc !== 32'h34) begin
                failures++;
                $display("FAIL stall_hold c=%0d ov=%b ir=%b rd_value=%h rd=%0d npc=%h exp=1/0/30/9/34",
                    c, out_valid, in_ready, rd_value, rd_addr, next_pc);
            end
        end
        in_valid = 1'b0;
        accept();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release ov=%b ir=%b exp=0/1", out_valid, in_ready);
        end
        ins = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
        issue(ins, 32'h100, 32'd3, 32'd3, 32'h20);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || next_pc !== 32'h0
            || rd_value !== 32'h0 || branch_taken !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset ov=%b ir=%b npc=%h rdv=%h taken=%b exp=0/0/0/0/0",
                out_valid, in_ready, next_pc, rd_value, branch_taken);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_release ir=%b ov=%b exp=1/0", in_ready, out_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_report ov=%b exp=0", out_valid);
        end
        ins = {7'b0000000, 5'd2, 5'd1, 3'b100, 5'd10, 7'b0110011};
        issue(ins, 32'h700, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0);
        wait_done(lat);
        checks++;
        if (rd_value !== 32'hFF00FF00 || lat !== 2 || next_pc !== 32'h704) begin
            failures++;
            $display("FAIL recover_xor rd_value=%h lat=%0d npc=%h exp=ff00ff00/2/704",
                rd_value, lat, next_pc);
        end
        accept();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        instr = '0;
        pc = '0;
        rs1_val = '0;
        rs2_val = '0;
        imm = '0;
        test_reset();
        test_arith();
        test_shift();
        test_branch();
        test_jump_mem();
        test_illegal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
